fetch_ctrl: RTL and testbench

Fetch sequencer between the instruction memory and the decode stage. Owns the fetch PC, issues one instruction-memory request per cycle through a request/grant handshake, and buffers returned words in a 2-entry queue so decode back-pressure never loses an instruction. Accepts redirects (branches, jumps, exceptions) that flush all buffered and in-flight fetches and restart at a new PC.

---
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Fetch sequencer between instruction memory and decode. Owns the fetch PC,
//   issues at most one instruction-memory request per cycle over a req/gnt
//   handshake and buffers returned words in a 2-entry FIFO so decode
//   back-pressure never drops an instruction. A redirect flushes everything
//   buffered or in flight and restarts fetch at the new PC.
//
// Parameters
//   RESET_PC        fetch PC loaded on reset (word aligned)
// Ports
//   clk             clock, rising edge
//   reset           asynchronous, active-high reset
//   enable          1 = may issue fetches; 0 = stop issuing, keep draining
//   redirect_valid  single-cycle redirect strobe
//   redirect_pc     new fetch PC (bits [1:0] ignored)
//   imem_req        fetch request
//   imem_addr       byte address of requested word (= fetch PC)
//   imem_gnt        memory accepts request when imem_req && imem_gnt
//   imem_rdata      instruction word, valid 1 cycle after acceptance
//   if_valid        FIFO head valid toward decode
//   if_ready        decode pops the head when if_valid && if_ready
//   if_pc           PC of the FIFO head
//   if_instr        instruction word of the FIFO head
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_fifo_pc    [2];
    logic [31:0] r_fifo_instr [2];
    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;

    logic        w_pop;
    logic        w_push;
    logic        w_req;
    logic        w_accept;
    logic [2:0]  w_occ;
    logic        w_unused_lsbs;

    // Redirect targets are forced word aligned; the low bits carry no meaning.
    assign w_unused_lsbs = ^redirect_pc[1:0];

    assign if_valid = (r_count != 2'd0);
    assign if_pc    = r_fifo_pc[r_rd_ptr];
    assign if_instr = r_fifo_instr[r_rd_ptr];

    assign w_pop  = if_valid && if_ready;
    assign w_push = r_inflight && !redirect_valid;

    // Occupancy after this cycle's pop, counting the word still in flight.
    // Issuing only while it is below 2 guarantees the returning word always
    // finds a free FIFO slot, so no overflow handling is needed.
    assign w_occ    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_req    = (r_state == RUN) && !redirect_valid && (w_occ < 3'd2);
    assign w_accept = w_req && imem_gnt;

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_fetch_pc      <= RESET_PC;
            r_inflight      <= 1'b0;
            r_inflight_pc   <= '0;
            r_fifo_pc[0]    <= '0;
            r_fifo_pc[1]    <= '0;
            r_fifo_instr[0] <= '0;
            r_fifo_instr[1] <= '0;
            r_count         <= '0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
        end else begin
            r_state <= enable ? RUN : IDLE;

            if (redirect_valid) begin
                // Flush wins over any pop or response arriving this cycle.
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_inflight <= 1'b0;
                r_count    <= '0;
                r_rd_ptr   <= 1'b0;
                r_wr_ptr   <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc    <= r_fetch_pc + 32'd4;
                    r_inflight_pc <= r_fetch_pc;
                end
                r_inflight <= w_accept;

                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
                    r_fifo_instr[r_wr_ptr] <= imem_rdata;
                    r_wr_ptr               <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed vector table, hand-written reset and
// PC-wrap sequences, and a randomized run checked against a queue-based model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable, redirect_valid, imem_gnt, if_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_pc, if_instr;

    logic        enable2, redirect_valid2, imem_gnt2, if_ready2;
    logic [31:0] redirect_pc2, imem_rdata2;
    logic        imem_req2, if_valid2;
    logic [31:0] imem_addr2, if_pc2, if_instr2;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
        .imem_rdata(imem_rdata2), .if_valid(if_valid2), .if_ready(if_ready2),
        .if_pc(if_pc2), .if_instr(if_instr2)
    );

    int total = 0;
    int bad   = 0;

    // Memory contents: a bijective scramble of the address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory side: returns the word for the request accepted last cycle.
    logic        acc_prev = 1'b0;
    logic [31:0] acc_addr = '0;

    task automatic cycle(input logic en, input logic rd, input logic [31:0] rpc,
                         input logic g, input logic r);
        @(negedge clk);
        imem_rdata     = acc_prev ? word(acc_addr) : $urandom();
        enable         = en;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_gnt       = g;
        if_ready       = r;
        #1;
        acc_prev = imem_req && imem_gnt;
        acc_addr = imem_addr;
    endtask

    typedef struct {
        logic        en, redir;
        logic [31:0] rpc;
        logic        gnt, rdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic en, input logic rd, input logic [31:0] rpc,
                       input logic g, input logic r, input logic ereq,
                       input logic [31:0] eaddr, input logic ev, input logic [31:0] epc);
        vec_t v;
        v.en = en; v.redir = rd; v.rpc = rpc; v.gnt = g; v.rdy = r;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = ev; v.epc = epc;
        vecs.push_back(v);
    endtask

    // Reference model state
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        q[$];
    logic        m_run, m_infl;
    logic [31:0] m_pc, m_ipc;
    logic        r_en, r_rd, r_g, r_r, m_ev, m_pop, m_req;
    logic [31:0] r_rpc;
    int          m_occ;

    logic        acc2;
    logic [31:0] a2;
    logic [31:0] wrap_pc [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        enable = 0; redirect_valid = 0; redirect_pc = '0; imem_gnt = 0;
        imem_rdata = '0; if_ready = 0;
        enable2 = 0; redirect_valid2 = 0; redirect_pc2 = '0; imem_gnt2 = 1;
        imem_rdata2 = '0; if_ready2 = 1;

        // ---- reset values ----
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", if_valid, 0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);
        chk("rst_req_wrap", imem_req2, 0);
        reset = 1'b0;

        // ---- directed table: startup, decode stall, redirect, grant stall, idle ----
        add(1,0,0,1,1, 0,32'h000,0,0);
        add(1,0,0,1,1, 1,32'h000,0,0);
        add(1,0,0,1,1, 1,32'h004,0,0);
        add(1,0,0,1,1, 1,32'h008,1,32'h000);
        add(1,0,0,1,1, 1,32'h00C,1,32'h004);
        for (int i = 0; i < 10; i++) add(1,0,0,1,0, 0,32'h010,1,32'h008);
        add(1,0,0,1,1, 1,32'h010,1,32'h008);
        add(1,0,0,1,1, 1,32'h014,1,32'h00C);
        add(1,0,0,1,1, 1,32'h018,1,32'h010);
        add(1,1,32'h103,1,0, 0,32'h01C,1,32'h014);
        add(1,0,0,1,1, 1,32'h100,0,0);
        add(1,0,0,1,1, 1,32'h104,0,0);
        add(1,0,0,1,1, 1,32'h108,1,32'h100);
        add(1,0,0,0,1, 1,32'h10C,1,32'h104);
        add(1,0,0,0,1, 1,32'h10C,1,32'h108);
        add(1,0,0,1,1, 1,32'h10C,0,0);
        add(1,0,0,1,1, 1,32'h110,0,0);
        add(1,0,0,1,1, 1,32'h114,1,32'h10C);
        add(0,0,0,1,1, 1,32'h118,1,32'h110);
        add(0,0,0,1,1, 0,32'h11C,1,32'h114);
        add(0,0,0,1,1, 0,32'h11C,1,32'h118);
        add(0,0,0,1,1, 0,32'h11C,0,0);
        add(0,1,32'h200,1,1, 0,32'h11C,0,0);
        add(0,0,0,1,1, 0,32'h200,0,0);

        foreach (vecs[k]) begin
            cycle(vecs[k].en, vecs[k].redir, vecs[k].rpc, vecs[k].gnt, vecs[k].rdy);
            chk($sformatf("vec%0d_req", k), imem_req, vecs[k].ereq);
            chk($sformatf("vec%0d_addr", k), imem_addr, vecs[k].eaddr);
            chk($sformatf("vec%0d_valid", k), if_valid, vecs[k].evalid);
            if (vecs[k].evalid) begin
                chk($sformatf("vec%0d_pc", k), if_pc, vecs[k].epc);
                chk($sformatf("vec%0d_instr", k), if_instr, word(vecs[k].epc));
            end
        end

        // ---- asynchronous reset mid-stream (one buffered, one returning) ----
        cycle(1,0,0,1,0);
        cycle(1,0,0,1,0);
        cycle(1,0,0,1,0);
        chk("mid_req", imem_req, 1);
        chk("mid_addr", imem_addr, 32'h204);
        @(negedge clk);
        imem_rdata = acc_prev ? word(acc_addr) : $urandom();
        enable = 0; imem_gnt = 0; if_ready = 0; redirect_valid = 0;
        #1;
        chk("mid_pre_valid", if_valid, 1);
        chk("mid_pre_pc", if_pc, 32'h200);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_valid", if_valid, 0);
        chk("mid_rst_pc", if_pc, 32'h0);
        chk("mid_rst_instr", if_instr, 32'h0);
        #1;
        reset = 1'b0;
        acc_prev = 1'b0;

        // ---- randomized run against the model; starts right after reset ----
        m_run = 0; m_infl = 0; m_pc = 32'h0; m_ipc = 32'h0;
        q.delete();
        for (int c = 0; c < 2000; c++) begin
            if (c < 6) begin
                r_en = 1; r_rd = 0; r_g = 1; r_r = 1;
            end else begin
                r_en = ($urandom_range(0, 9) != 0);
                r_rd = ($urandom_range(0, 19) == 0);
                r_g  = 1'($urandom_range(0, 1));
                r_r  = 1'($urandom_range(0, 1));
            end
            r_rpc = $urandom();
            cycle(r_en, r_rd, r_rpc, r_g, r_r);

            m_ev  = (q.size() != 0);
            m_pop = m_ev && r_r;
            m_occ = q.size() + (m_infl ? 1 : 0) - (m_pop ? 1 : 0);
            m_req = m_run && !r_rd && (m_occ < 2);

            chk("rnd_req", imem_req, m_req);
            chk("rnd_addr", imem_addr, m_pc);
            chk("rnd_valid", if_valid, m_ev);
            if (m_ev) begin
                chk("rnd_pc", if_pc, q[0].pc);
                chk("rnd_instr", if_instr, q[0].instr);
            end

            if (r_rd) begin
                q.delete();
                m_infl = 0;
                m_pc   = {r_rpc[31:2], 2'b00};
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_infl) q.push_back('{pc: m_ipc, instr: word(m_ipc)});
                if (m_req && r_g) begin
                    m_infl = 1;
                    m_ipc  = m_pc;
                    m_pc   = m_pc + 32'd4;
                end else begin
                    m_infl = 0;
                end
            end
            m_run = r_en;
        end

        // ---- PC wrap with RESET_PC = FFFF_FFF8 ----
        wrap_pc[0] = 32'hFFFF_FFF8;
        wrap_pc[1] = 32'hFFFF_FFFC;
        wrap_pc[2] = 32'h0000_0000;
        wrap_pc[3] = 32'h0000_0004;
        acc2 = 1'b0;
        a2   = '0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            imem_rdata2 = acc2 ? word(a2) : $urandom();
            enable2 = 1'b1;
            #1;
            if (k == 1) chk("wrap_addr1", imem_addr2, 32'hFFFF_FFF8);
            if (k == 2) chk("wrap_addr2", imem_addr2, 32'hFFFF_FFFC);
            if (k == 3) chk("wrap_addr3", imem_addr2, 32'h0000_0000);
            if (k >= 1) chk("wrap_req", imem_req2, 1);
            if (k >= 3) begin
                chk("wrap_valid", if_valid2, 1);
                chk("wrap_pc", if_pc2, wrap_pc[k-3]);
                chk("wrap_instr", if_instr2, word(wrap_pc[k-3]));
            end else begin
                chk("wrap_valid_early", if_valid2, 0);
            end
            acc2 = imem_req2 && imem_gnt2;
            a2   = imem_addr2;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
